// File: rtl/xge_tx_arbiter.sv
// Two-source, packet-granular round-robin arbiter feeding the xge_mac pkt_tx interface.
// Whole packets are popped from FWFT source FIFOs; malformed packets are discarded.
module xge_tx_arbiter #(
  parameter int IFG_CYCLES = 0,
  parameter int CNT_W      = 16
) (
  input  logic             clk_156m25,
  input  logic             reset_156m25_n,
  input  logic             arb_en,
  input  logic             src0_val,
  input  logic             src0_sop,
  input  logic             src0_eop,
  input  logic [2:0]       src0_mod,
  input  logic [63:0]      src0_data,
  output logic             src0_ren,
  input  logic             src1_val,
  input  logic             src1_sop,
  input  logic             src1_eop,
  input  logic [2:0]       src1_mod,
  input  logic [63:0]      src1_data,
  output logic             src1_ren,
  input  logic             pkt_tx_full,
  output logic             pkt_tx_val,
  output logic             pkt_tx_sop,
  output logic             pkt_tx_eop,
  output logic [2:0]       pkt_tx_mod,
  output logic [63:0]      pkt_tx_data,
  output logic             active_src,
  output logic             busy,
  output logic             err_pulse,
  output logic [CNT_W-1:0] pkt_cnt0,
  output logic [CNT_W-1:0] pkt_cnt1
);

  typedef enum logic [1:0] {IDLE, XFER, DROP, GAP} state_t;

  localparam bit         HAS_GAP  = (IFG_CYCLES > 0);
  localparam logic [3:0] GAP_LAST = 4'(HAS_GAP ? IFG_CYCLES - 1 : 0);

  state_t     state;
  logic       rr_ptr;
  logic       first_word;
  logic [3:0] gap_cnt;

  logic        cur_val;
  logic        cur_sop;
  logic        cur_eop;
  logic [2:0]  cur_mod;
  logic [63:0] cur_data;
  logic        pop;

  assign cur_val  = active_src ? src1_val  : src0_val;
  assign cur_sop  = active_src ? src1_sop  : src0_sop;
  assign cur_eop  = active_src ? src1_eop  : src0_eop;
  assign cur_mod  = active_src ? src1_mod  : src0_mod;
  assign cur_data = active_src ? src1_data : src0_data;

  // Back-pressure only applies while forwarding; a dropped packet drains regardless.
  always_comb begin
    pop = 1'b0;
    case (state)
      XFER:    pop = cur_val & ~pkt_tx_full;
      DROP:    pop = cur_val;
      default: pop = 1'b0;
    endcase
  end

  assign src0_ren = pop & ~active_src;
  assign src1_ren = pop & active_src;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      state       <= IDLE;
      rr_ptr      <= 1'b0;
      first_word  <= 1'b0;
      gap_cnt     <= '0;
      active_src  <= 1'b0;
      pkt_tx_val  <= 1'b0;
      pkt_tx_sop  <= 1'b0;
      pkt_tx_eop  <= 1'b0;
      pkt_tx_mod  <= '0;
      pkt_tx_data <= '0;
      err_pulse   <= 1'b0;
      pkt_cnt0    <= '0;
      pkt_cnt1    <= '0;
    end else begin
      pkt_tx_val <= 1'b0;
      pkt_tx_sop <= 1'b0;
      pkt_tx_eop <= 1'b0;
      pkt_tx_mod <= '0;
      err_pulse  <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_en && (src0_val || src1_val)) begin
            active_src <= (src0_val && src1_val) ? rr_ptr : src1_val;
            first_word <= 1'b1;
            state      <= XFER;
          end
        end
        XFER: begin
          if (pop) begin
            first_word <= 1'b0;
            if (first_word && !cur_sop) begin
              err_pulse <= 1'b1;
              if (cur_eop) begin
                rr_ptr  <= ~active_src;
                gap_cnt <= '0;
                state   <= HAS_GAP ? GAP : IDLE;
              end else begin
                state <= DROP;
              end
            end else begin
              pkt_tx_val  <= 1'b1;
              pkt_tx_sop  <= first_word;
              pkt_tx_eop  <= cur_eop;
              pkt_tx_mod  <= cur_eop ? cur_mod : 3'd0;
              pkt_tx_data <= cur_data;
              if (!first_word && cur_sop) err_pulse <= 1'b1;
              if (cur_eop) begin
                if (active_src) pkt_cnt1 <= pkt_cnt1 + CNT_W'(1);
                else            pkt_cnt0 <= pkt_cnt0 + CNT_W'(1);
                rr_ptr  <= ~active_src;
                gap_cnt <= '0;
                state   <= HAS_GAP ? GAP : IDLE;
              end
            end
          end
        end
        DROP: begin
          if (pop && cur_eop) begin
            rr_ptr  <= ~active_src;
            gap_cnt <= '0;
            state   <= HAS_GAP ? GAP : IDLE;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) state <= IDLE;
          else                     gap_cnt <= gap_cnt + 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xge_tx_arbiter.sv
// Bench for xge_tx_arbiter: FWFT source models, a packet-level round-robin model and
// an every-cycle output comparator; one instance uses IFG_CYCLES=0, another IFG_CYCLES=3.
module tb_xge_tx_arbiter;

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [2:0]  mod;
    logic [63:0] data;
  } word_t;

  logic clk_156m25 = 1'b0;
  always #5 clk_156m25 = ~clk_156m25;

  logic        reset_156m25_n;
  logic        arb_en;
  logic        pkt_tx_full;
  logic        src0_val, src0_sop, src0_eop, src0_ren;
  logic [2:0]  src0_mod;
  logic [63:0] src0_data;
  logic        src1_val, src1_sop, src1_eop, src1_ren;
  logic [2:0]  src1_mod;
  logic [63:0] src1_data;
  logic        pkt_tx_val, pkt_tx_sop, pkt_tx_eop, active_src, busy, err_pulse;
  logic [2:0]  pkt_tx_mod;
  logic [63:0] pkt_tx_data;
  logic [15:0] pkt_cnt0, pkt_cnt1;

  logic        g_val, g_sop, g_eop, g_ren, g_ren1;
  logic [2:0]  g_mod;
  logic [63:0] g_data;
  logic        g_tx_val, g_tx_sop, g_tx_eop, g_active, g_busy, g_err;
  logic [2:0]  g_tx_mod;
  logic [63:0] g_tx_data;
  logic [15:0] g_cnt0, g_cnt1;

  xge_tx_arbiter #(.IFG_CYCLES(0), .CNT_W(16)) dut (
    .clk_156m25(clk_156m25), .reset_156m25_n(reset_156m25_n), .arb_en(arb_en),
    .src0_val(src0_val), .src0_sop(src0_sop), .src0_eop(src0_eop), .src0_mod(src0_mod),
    .src0_data(src0_data), .src0_ren(src0_ren),
    .src1_val(src1_val), .src1_sop(src1_sop), .src1_eop(src1_eop), .src1_mod(src1_mod),
    .src1_data(src1_data), .src1_ren(src1_ren),
    .pkt_tx_full(pkt_tx_full), .pkt_tx_val(pkt_tx_val), .pkt_tx_sop(pkt_tx_sop),
    .pkt_tx_eop(pkt_tx_eop), .pkt_tx_mod(pkt_tx_mod), .pkt_tx_data(pkt_tx_data),
    .active_src(active_src), .busy(busy), .err_pulse(err_pulse),
    .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
  );

  xge_tx_arbiter #(.IFG_CYCLES(3), .CNT_W(16)) dut_gap (
    .clk_156m25(clk_156m25), .reset_156m25_n(reset_156m25_n), .arb_en(arb_en),
    .src0_val(g_val), .src0_sop(g_sop), .src0_eop(g_eop), .src0_mod(g_mod),
    .src0_data(g_data), .src0_ren(g_ren),
    .src1_val(1'b0), .src1_sop(1'b0), .src1_eop(1'b0), .src1_mod(3'd0),
    .src1_data(64'd0), .src1_ren(g_ren1),
    .pkt_tx_full(1'b0), .pkt_tx_val(g_tx_val), .pkt_tx_sop(g_tx_sop),
    .pkt_tx_eop(g_tx_eop), .pkt_tx_mod(g_tx_mod), .pkt_tx_data(g_tx_data),
    .active_src(g_active), .busy(g_busy), .err_pulse(g_err),
    .pkt_cnt0(g_cnt0), .pkt_cnt1(g_cnt1)
  );

  word_t mem0[$], mem1[$], memg[$];
  int    rd0, rd1, rdg, st0, st1;
  int    pk0_start[$], pk0_len[$], pk1_start[$], pk1_len[$];
  word_t exp_m[$], exp_g[$];
  logic  m_rr;
  int    m_cnt0, m_cnt1, m_err, m_cntg;
  int    obs_err, obs_err_g, cyc;
  int    last_eop_m, last_eop_g;
  int    gaps_m[$], gaps_g[$], sopsrc_m[$];
  int    total, bad;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic refresh();
    word_t w0, w1, wg;
    w0 = '0; w1 = '0; wg = '0;
    if (rd0 < mem0.size()) w0 = mem0[rd0];
    if (rd1 < mem1.size()) w1 = mem1[rd1];
    if (rdg < memg.size()) wg = memg[rdg];
    src0_val = (rd0 < mem0.size());
    src1_val = (rd1 < mem1.size());
    g_val    = (rdg < memg.size());
    {src0_sop, src0_eop, src0_mod, src0_data} = w0;
    {src1_sop, src1_eop, src1_mod, src1_data} = w1;
    {g_sop, g_eop, g_mod, g_data} = wg;
  endtask

  // Pops are taken from the read enables as they stand just before the clock edge.
  task automatic tick();
    logic p0, p1, pg;
    @(negedge clk_156m25);
    p0 = src0_ren; p1 = src1_ren; pg = g_ren;
    @(posedge clk_156m25);
    #1;
    if (p0) rd0++;
    if (p1) rd1++;
    if (pg) rdg++;
    refresh();
  endtask

  // Source 2 means the single source of the IFG_CYCLES=3 instance.
  task automatic applyStimulus(input int src, input logic sop, input logic eop,
                               input logic [2:0] mod, input logic [63:0] data);
    word_t w, o;
    w = {sop, eop, mod, data};
    if (src == 0) begin
      if (st0 < 0) st0 = mem0.size();
      mem0.push_back(w);
      if (eop) begin pk0_start.push_back(st0); pk0_len.push_back(mem0.size() - st0); st0 = -1; end
    end else if (src == 1) begin
      if (st1 < 0) st1 = mem1.size();
      mem1.push_back(w);
      if (eop) begin pk1_start.push_back(st1); pk1_len.push_back(mem1.size() - st1); st1 = -1; end
    end else begin
      memg.push_back(w);
      o = w;
      if (!eop) o.mod = 3'd0;
      exp_g.push_back(o);
      if (eop) m_cntg++;
    end
    refresh();
  endtask

  // Packet-level model: pick by round robin when both hold a packet, drop packets
  // whose first word lacks sop, clear stray mid-packet sops, flip priority per packet.
  task automatic build_model();
    int pick, start, len;
    logic dropped;
    word_t w, o;
    while (pk0_start.size() > 0 || pk1_start.size() > 0) begin
      if (pk0_start.size() > 0 && pk1_start.size() > 0) pick = int'(m_rr);
      else pick = (pk1_start.size() > 0) ? 1 : 0;
      if (pick == 1) begin start = pk1_start.pop_front(); len = pk1_len.pop_front(); end
      else           begin start = pk0_start.pop_front(); len = pk0_len.pop_front(); end
      dropped = 1'b0;
      for (int i = 0; i < len && !dropped; i++) begin
        w = (pick == 1) ? mem1[start + i] : mem0[start + i];
        if (i == 0 && !w.sop) begin
          m_err++;
          dropped = 1'b1;
        end else begin
          if (i > 0 && w.sop) m_err++;
          o.sop  = (i == 0);
          o.eop  = w.eop;
          o.mod  = w.eop ? w.mod : 3'd0;
          o.data = w.data;
          exp_m.push_back(o);
        end
      end
      if (!dropped) begin
        if (pick == 1) m_cnt1++;
        else m_cnt0++;
      end
      m_rr = (pick == 0);
    end
  endtask

  task automatic assert_reset();
    reset_156m25_n = 1'b0;
    mem0.delete(); mem1.delete(); memg.delete();
    rd0 = 0; rd1 = 0; rdg = 0; st0 = -1; st1 = -1;
    pk0_start.delete(); pk0_len.delete(); pk1_start.delete(); pk1_len.delete();
    exp_m.delete(); exp_g.delete();
    m_rr = 1'b0; m_cnt0 = 0; m_cnt1 = 0; m_err = 0; m_cntg = 0;
    obs_err = 0; obs_err_g = 0;
    refresh();
  endtask

  task automatic release_reset();
    tick();
    tick();
    reset_156m25_n = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_m.size() > 0 || exp_g.size() > 0 || busy || g_busy ||
            rd0 < mem0.size() || rd1 < mem1.size() || rdg < memg.size()) && n < 400) begin
      tick();
      n++;
    end
    tick();
    tick();
    checkOutput({name, "_drained"}, 128'(n < 400), 128'(1));
    checkOutput({name, "_left"}, 128'(exp_m.size() + exp_g.size()), 128'(0));
    checkOutput({name, "_cnt0"}, 128'(pkt_cnt0), 128'(16'(m_cnt0)));
    checkOutput({name, "_cnt1"}, 128'(pkt_cnt1), 128'(16'(m_cnt1)));
    checkOutput({name, "_gcnt0"}, 128'(g_cnt0), 128'(16'(m_cntg)));
    checkOutput({name, "_err"}, 128'(obs_err), 128'(m_err));
    checkOutput({name, "_gerr"}, 128'(obs_err_g), 128'(0));
  endtask

  // Every-cycle comparator: output words against the model, bubbles clean, gaps respected.
  initial begin
    cyc = 0;
    last_eop_m = -1;
    last_eop_g = -1;
    forever begin : cmp
      word_t a, e;
      @(negedge clk_156m25);
      cyc++;
      if (!reset_156m25_n) begin
        last_eop_m = -1;
        last_eop_g = -1;
      end else begin
        a = {pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, pkt_tx_data};
        if (pkt_tx_val) begin
          e = '0;
          if (exp_m.size() > 0) e = exp_m.pop_front();
          else begin bad++; total++; $display("[TB] FAIL m_unexpected_word actual=%0h required=none", a); end
          checkOutput("m_word", 128'(a), 128'(e));
          if (pkt_tx_sop) begin
            sopsrc_m.push_back(int'(active_src));
            if (last_eop_m >= 0) begin
              gaps_m.push_back(cyc - last_eop_m - 1);
              checkOutput("m_gap_min", 128'(cyc - last_eop_m - 1 >= 1), 128'(1));
            end
          end
          if (pkt_tx_eop) last_eop_m = cyc;
        end else begin
          checkOutput("m_bubble", 128'({pkt_tx_sop, pkt_tx_eop, pkt_tx_mod}), 128'(0));
        end
        a = {g_tx_sop, g_tx_eop, g_tx_mod, g_tx_data};
        if (g_tx_val) begin
          e = '0;
          if (exp_g.size() > 0) e = exp_g.pop_front();
          else begin bad++; total++; $display("[TB] FAIL g_unexpected_word actual=%0h required=none", a); end
          checkOutput("g_word", 128'(a), 128'(e));
          if (g_tx_sop && last_eop_g >= 0) begin
            gaps_g.push_back(cyc - last_eop_g - 1);
            checkOutput("g_gap_min", 128'(cyc - last_eop_g - 1 >= 4), 128'(1));
          end
          if (g_tx_eop) last_eop_g = cyc;
        end else begin
          checkOutput("g_bubble", 128'({g_tx_sop, g_tx_eop, g_tx_mod}), 128'(0));
        end
        if (err_pulse) obs_err++;
        if (g_err) obs_err_g++;
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int ord, base_err, base_cnt1;
    logic all_one;
    total = 0; bad = 0;
    arb_en = 1'b1;
    pkt_tx_full = 1'b0;
    reset_156m25_n = 1'b1;
    #2;
    assert_reset();
    tick();
    checkOutput("rst_val", 128'({pkt_tx_val, busy, active_src, err_pulse}), 128'(0));
    checkOutput("rst_cnt", 128'({pkt_cnt0, pkt_cnt1}), 128'(0));
    release_reset();

    // Single src0 packet: sop two cycles after src0_val, then contiguous words.
    applyStimulus(0, 1'b1, 1'b0, 3'd0, 64'hAABBCCDDEEFF0011);
    applyStimulus(0, 1'b0, 1'b0, 3'd0, 64'h2233445566778899);
    applyStimulus(0, 1'b0, 1'b1, 3'd1, 64'hDEADBEEFCAFEBABE);
    build_model();
    tick();
    checkOutput("t1_no_early_val", 128'(pkt_tx_val), 128'(0));
    tick();
    checkOutput("t1_w0", 128'({pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, pkt_tx_data}),
                128'({1'b1, 1'b1, 1'b0, 3'd0, 64'hAABBCCDDEEFF0011}));
    tick();
    checkOutput("t1_w1", 128'({pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, pkt_tx_data}),
                128'({1'b1, 1'b0, 1'b0, 3'd0, 64'h2233445566778899}));
    tick();
    checkOutput("t1_w2", 128'({pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, pkt_tx_data}),
                128'({1'b1, 1'b0, 1'b1, 3'd1, 64'hDEADBEEFCAFEBABE}));
    wait_drain("t1");
    checkOutput("t1_cnt0_lit", 128'(pkt_cnt0), 128'(1));

    // Both sources with two packets each, starting from a fresh round-robin pointer.
    assert_reset();
    release_reset();
    sopsrc_m.delete(); gaps_m.delete();
    for (int p = 0; p < 2; p++) begin
      applyStimulus(0, 1'b1, 1'b0, 3'd0, 64'h0A00_0000_0000_0000 + 64'(p * 16));
      applyStimulus(0, 1'b0, 1'b1, 3'd3, 64'h0A00_0000_0000_0001 + 64'(p * 16));
      applyStimulus(1, 1'b1, 1'b0, 3'd0, 64'h0B00_0000_0000_0000 + 64'(p * 16));
      applyStimulus(1, 1'b0, 1'b1, 3'd5, 64'h0B00_0000_0000_0001 + 64'(p * 16));
    end
    build_model();
    wait_drain("t2");
    ord = 0;
    foreach (sopsrc_m[i]) ord = ord * 2 + sopsrc_m[i];
    checkOutput("t2_sop_count", 128'(sopsrc_m.size()), 128'(4));
    checkOutput("t2_order", 128'(ord), 128'(4'b0101));
    all_one = 1'b1;
    foreach (gaps_m[i]) if (gaps_m[i] != 1) all_one = 1'b0;
    checkOutput("t2_gaps", 128'({gaps_m.size() == 3, all_one}), 128'(2'b11));
    checkOutput("t2_cnt_lit", 128'({pkt_cnt0, pkt_cnt1}), 128'({16'd2, 16'd2}));

    // Back-pressure for four cycles in the middle of a five-word packet.
    applyStimulus(0, 1'b1, 1'b0, 3'd0, 64'hF0F0_0000_0000_0000);
    for (int i = 1; i < 4; i++) applyStimulus(0, 1'b0, 1'b0, 3'd0, 64'hF0F0_0000_0000_0000 + 64'(i));
    applyStimulus(0, 1'b0, 1'b1, 3'd6, 64'hF0F0_0000_0000_0004);
    build_model();
    tick();
    tick();
    checkOutput("t3_sop", 128'({pkt_tx_val, pkt_tx_sop}), 128'(2'b11));
    pkt_tx_full = 1'b1;
    #1;
    checkOutput("t3_ren_full", 128'(src0_ren), 128'(0));
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("t3_bubble", 128'({pkt_tx_val, src0_ren}), 128'(0));
    end
    pkt_tx_full = 1'b0;
    wait_drain("t3");

    // src1 fragment without sop, then a well-formed src1 packet.
    base_err = obs_err;
    base_cnt1 = int'(pkt_cnt1);
    applyStimulus(1, 1'b0, 1'b0, 3'd0, 64'h5555_0000_0000_0001);
    applyStimulus(1, 1'b0, 1'b0, 3'd0, 64'h5555_0000_0000_0002);
    applyStimulus(1, 1'b0, 1'b1, 3'd2, 64'h5555_0000_0000_0003);
    applyStimulus(1, 1'b1, 1'b0, 3'd0, 64'h6666_0000_0000_0001);
    applyStimulus(1, 1'b0, 1'b1, 3'd7, 64'h6666_0000_0000_0002);
    build_model();
    wait_drain("t4");
    checkOutput("t4_err_lit", 128'(obs_err - base_err), 128'(1));
    checkOutput("t4_cnt1_lit", 128'(int'(pkt_cnt1) - base_cnt1), 128'(1));

    // IFG_CYCLES=3 instance, two back-to-back packets.
    gaps_g.delete();
    applyStimulus(2, 1'b1, 1'b0, 3'd0, 64'h7777_0000_0000_0001);
    applyStimulus(2, 1'b0, 1'b1, 3'd4, 64'h7777_0000_0000_0002);
    applyStimulus(2, 1'b1, 1'b0, 3'd0, 64'h8888_0000_0000_0001);
    applyStimulus(2, 1'b0, 1'b1, 3'd0, 64'h8888_0000_0000_0002);
    wait_drain("t5");
    checkOutput("t5_gap_lit", 128'({gaps_g.size() == 1, gaps_g.size() > 0 ? gaps_g[0] : -1}),
                128'({1'b1, 32'd4}));
    checkOutput("t5_gcnt_lit", 128'(g_cnt0), 128'(2));

    // Reset in the middle of a src1 packet, then hold off grants with arb_en low.
    for (int i = 0; i < 6; i++)
      applyStimulus(1, i == 0, i == 5, 3'd0, 64'h9999_0000_0000_0000 + 64'(i));
    build_model();
    tick();
    tick();
    tick();
    checkOutput("t6_midpkt", 128'({pkt_tx_val, active_src, busy}), 128'(3'b111));
    assert_reset();
    #1;
    checkOutput("t6_rst_out", 128'({pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, pkt_tx_data}), 128'(0));
    checkOutput("t6_rst_misc", 128'({active_src, busy, err_pulse, pkt_cnt0, pkt_cnt1}), 128'(0));
    arb_en = 1'b0;
    release_reset();
    applyStimulus(0, 1'b1, 1'b0, 3'd0, 64'hABCD_0000_0000_0001);
    applyStimulus(0, 1'b0, 1'b1, 3'd0, 64'hABCD_0000_0000_0002);
    build_model();
    for (int i = 0; i < 8; i++) begin
      tick();
      checkOutput("t6_hold", 128'({busy, src0_ren, pkt_tx_val}), 128'(0));
    end
    arb_en = 1'b1;
    wait_drain("t6");
    checkOutput("t6_cnt_lit", 128'({pkt_cnt0, pkt_cnt1}), 128'({16'd1, 16'd0}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
